// File: rtl/clint_pkg.sv
// Shared constants, state enums and payload types for the core-local interruptor.
package clint_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned OFF_W  = 16;
    localparam int unsigned HART_W = 4;

    localparam logic [OFF_W-1:0] MSIP_OFF         = 16'h0000;
    localparam logic [OFF_W-1:0] MTIMECMP_OFF     = 16'h4000;
    localparam logic [OFF_W-1:0] MTIME_OFF        = 16'hBFF8;
    localparam logic [OFF_W-1:0] LEGACY_MTIME_OFF = 16'h0048;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP} wr_state_e;
    typedef enum logic {R_IDLE, R_RESP} rd_state_e;

    typedef enum logic [2:0] {
        SEL_NONE, SEL_MSIP, SEL_CMP_LO, SEL_CMP_HI,
        SEL_MTIME_LO, SEL_MTIME_HI, SEL_LEGACY_LO, SEL_LEGACY_HI
    } reg_sel_e;

    typedef struct packed {
        reg_sel_e          sel;
        logic [HART_W-1:0] hart;
    } decode_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [STRB_W-1:0] strb;
    } wr_req_t;

    // Byte-lane merge of a strobed write into an existing word.
    function automatic logic [DATA_W-1:0] strb_merge(input logic [DATA_W-1:0] old,
                                                     input logic [DATA_W-1:0] data,
                                                     input logic [STRB_W-1:0] strb);
        logic [DATA_W-1:0] res;
        res = old;
        for (int b = 0; b < int'(STRB_W); b++) begin
            if (strb[b]) res[8*b +: 8] = data[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/clint_timebase.sv
// Prescaled 64-bit mtime counter; a write to either half wins over the tick.
module clint_timebase
    import clint_pkg::*;
#(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_lo,
    input  logic              wr_hi,
    input  logic [DATA_W-1:0] wdata,
    input  logic [STRB_W-1:0] wstrb,
    output logic [63:0]       mtime
);

    localparam int unsigned PS_W = 16;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);

    logic [PS_W-1:0] ps_q;
    logic [63:0]     mtime_q;

    // Halves are written independently, so a low write never carries upward.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ps_q    <= '0;
            mtime_q <= '0;
        end else if (wr_lo || wr_hi) begin
            ps_q <= '0;
            if (wr_lo) mtime_q[31:0]  <= strb_merge(mtime_q[31:0], wdata, wstrb);
            if (wr_hi) mtime_q[63:32] <= strb_merge(mtime_q[63:32], wdata, wstrb);
        end else if (ps_q == PS_LAST) begin
            ps_q    <= '0;
            mtime_q <= mtime_q + 64'd1;
        end else begin
            ps_q <= ps_q + PS_W'(1);
        end
    end

    assign mtime = mtime_q;

endmodule

// File: rtl/clint_multi.sv
// Core-local interruptor: mtime, per-hart mtimecmp/msip, AXI-lite-style slave port.
module clint_multi
    import clint_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
    parameter int unsigned NUM_HARTS = 1,
    parameter int unsigned TICK_DIV  = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 arvalid_i,
    output logic                 arready_o,
    input  logic [ADDR_W-1:0]    araddr_i,
    output logic                 rvalid_o,
    input  logic                 rready_i,
    output logic [DATA_W-1:0]    rdata_o,
    output logic [1:0]           rresp_o,
    input  logic                 awvalid_i,
    output logic                 awready_o,
    input  logic [ADDR_W-1:0]    awaddr_i,
    input  logic                 wvalid_i,
    output logic                 wready_o,
    input  logic [DATA_W-1:0]    wdata_i,
    input  logic [STRB_W-1:0]    wstrb_i,
    output logic                 bvalid_o,
    input  logic                 bready_i,
    output logic [1:0]           bresp_o,
    output logic [NUM_HARTS-1:0] msip_o,
    output logic [NUM_HARTS-1:0] mtip_o
);

    logic [63:0]          mtime;
    logic [63:0]          mtimecmp_q [NUM_HARTS];
    logic [NUM_HARTS-1:0] msip_q;
    logic [NUM_HARTS-1:0] mtip_q;

    // Map a bus address to a register select; unaligned or unmapped gives SEL_NONE.
    function automatic decode_t decode(input logic [ADDR_W-1:0] addr);
        decode_t           d;
        logic [ADDR_W-1:0] rel;
        logic [OFF_W-1:0]  off;
        d.sel  = SEL_NONE;
        d.hart = '0;
        rel    = addr - BASE_ADDR;
        off    = rel[OFF_W-1:0];
        if (rel[ADDR_W-1:OFF_W] == '0 && rel[1:0] == 2'b00) begin
            if (off == MTIME_OFF)                     d.sel = SEL_MTIME_LO;
            if (off == MTIME_OFF + 16'd4)             d.sel = SEL_MTIME_HI;
            if (off == LEGACY_MTIME_OFF)              d.sel = SEL_LEGACY_LO;
            if (off == LEGACY_MTIME_OFF + 16'd4)      d.sel = SEL_LEGACY_HI;
            for (int h = 0; h < int'(NUM_HARTS); h++) begin
                if (off == MSIP_OFF + OFF_W'(4*h)) begin
                    d.sel  = SEL_MSIP;
                    d.hart = HART_W'(h);
                end
                if (off == MTIMECMP_OFF + OFF_W'(8*h)) begin
                    d.sel  = SEL_CMP_LO;
                    d.hart = HART_W'(h);
                end
                if (off == MTIMECMP_OFF + OFF_W'(8*h + 4)) begin
                    d.sel  = SEL_CMP_HI;
                    d.hart = HART_W'(h);
                end
            end
        end
        return d;
    endfunction

    // ---------------- write channel ----------------
    wr_state_e   wr_state_q, wr_state_d;
    wr_req_t     wr_lat_q, wr_req;
    decode_t     wr_dec;
    logic        awready_q, wready_q, bvalid_q;
    logic [1:0]  bresp_q;
    logic        aw_hs, w_hs, wr_fire, wr_ok;

    assign aw_hs  = awvalid_i && awready_q;
    assign w_hs   = wvalid_i && wready_q;
    assign wr_dec = decode(wr_req.addr);
    assign wr_ok  = (wr_dec.sel != SEL_NONE) && (wr_dec.sel != SEL_LEGACY_LO) &&
                    (wr_dec.sel != SEL_LEGACY_HI);

    // The update fires in the cycle the second of AW/W is accepted.
    always_comb begin
        wr_state_d = wr_state_q;
        wr_req     = wr_lat_q;
        wr_fire    = 1'b0;
        case (wr_state_q)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    wr_req     = '{addr: awaddr_i, data: wdata_i, strb: wstrb_i};
                    wr_fire    = 1'b1;
                    wr_state_d = W_RESP;
                end else if (aw_hs) begin
                    wr_state_d = W_HAVE_A;
                end else if (w_hs) begin
                    wr_state_d = W_HAVE_D;
                end
            end
            W_HAVE_A: begin
                if (w_hs) begin
                    wr_req.data = wdata_i;
                    wr_req.strb = wstrb_i;
                    wr_fire     = 1'b1;
                    wr_state_d  = W_RESP;
                end
            end
            W_HAVE_D: begin
                if (aw_hs) begin
                    wr_req.addr = awaddr_i;
                    wr_fire     = 1'b1;
                    wr_state_d  = W_RESP;
                end
            end
            W_RESP:  if (bready_i) wr_state_d = W_IDLE;
            default: wr_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_state_q <= W_IDLE;
            wr_lat_q   <= '0;
            awready_q  <= 1'b1;
            wready_q   <= 1'b1;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
        end else begin
            wr_state_q <= wr_state_d;
            if (aw_hs) wr_lat_q.addr <= awaddr_i;
            if (w_hs) begin
                wr_lat_q.data <= wdata_i;
                wr_lat_q.strb <= wstrb_i;
            end
            awready_q <= (wr_state_d == W_IDLE) || (wr_state_d == W_HAVE_D);
            wready_q  <= (wr_state_d == W_IDLE) || (wr_state_d == W_HAVE_A);
            bvalid_q  <= (wr_state_d == W_RESP);
            if (wr_fire) bresp_q <= wr_ok ? RESP_OKAY : RESP_SLVERR;
        end
    end

    // Per-hart msip / mtimecmp storage.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            msip_q <= '0;
            for (int h = 0; h < int'(NUM_HARTS); h++) mtimecmp_q[h] <= '1;
        end else if (wr_fire) begin
            for (int h = 0; h < int'(NUM_HARTS); h++) begin
                if (wr_dec.hart == HART_W'(h)) begin
                    case (wr_dec.sel)
                        SEL_MSIP:   if (wr_req.strb[0]) msip_q[h] <= wr_req.data[0];
                        SEL_CMP_LO: mtimecmp_q[h][31:0]  <= strb_merge(mtimecmp_q[h][31:0],
                                                                       wr_req.data, wr_req.strb);
                        SEL_CMP_HI: mtimecmp_q[h][63:32] <= strb_merge(mtimecmp_q[h][63:32],
                                                                       wr_req.data, wr_req.strb);
                        default: ;
                    endcase
                end
            end
        end
    end

    clint_timebase #(.TICK_DIV(TICK_DIV)) u_timebase (
        .clock (clock),
        .reset (reset),
        .wr_lo (wr_fire && (wr_dec.sel == SEL_MTIME_LO)),
        .wr_hi (wr_fire && (wr_dec.sel == SEL_MTIME_HI)),
        .wdata (wr_req.data),
        .wstrb (wr_req.strb),
        .mtime (mtime)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mtip_q <= '0;
        end else begin
            for (int h = 0; h < int'(NUM_HARTS); h++) mtip_q[h] <= (mtime >= mtimecmp_q[h]);
        end
    end

    // ---------------- read channel ----------------
    rd_state_e          rd_state_q, rd_state_d;
    decode_t            rd_dec;
    logic               arready_q, rvalid_q, ar_hs;
    logic [DATA_W-1:0]  rdata_q, rd_word;
    logic [1:0]         rresp_q, rd_resp;

    assign ar_hs  = arvalid_i && arready_q;
    assign rd_dec = decode(araddr_i);

    always_comb begin
        rd_word = '0;
        rd_resp = RESP_OKAY;
        case (rd_dec.sel)
            SEL_MTIME_LO, SEL_LEGACY_LO: rd_word = mtime[31:0];
            SEL_MTIME_HI, SEL_LEGACY_HI: rd_word = mtime[63:32];
            SEL_MSIP, SEL_CMP_LO, SEL_CMP_HI: begin
                for (int h = 0; h < int'(NUM_HARTS); h++) begin
                    if (rd_dec.hart == HART_W'(h)) begin
                        if (rd_dec.sel == SEL_MSIP)        rd_word = {31'b0, msip_q[h]};
                        else if (rd_dec.sel == SEL_CMP_LO) rd_word = mtimecmp_q[h][31:0];
                        else                               rd_word = mtimecmp_q[h][63:32];
                    end
                end
            end
            default: rd_resp = RESP_SLVERR;
        endcase
    end

    always_comb begin
        rd_state_d = rd_state_q;
        case (rd_state_q)
            R_IDLE:  if (ar_hs) rd_state_d = R_RESP;
            R_RESP:  if (rready_i) rd_state_d = R_IDLE;
            default: rd_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_state_q <= R_IDLE;
            arready_q  <= 1'b1;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
        end else begin
            rd_state_q <= rd_state_d;
            arready_q  <= (rd_state_d == R_IDLE);
            rvalid_q   <= (rd_state_d == R_RESP);
            if (ar_hs) begin
                rdata_q <= rd_word;
                rresp_q <= rd_resp;
            end
        end
    end

    assign arready_o = arready_q;
    assign rvalid_o  = rvalid_q;
    assign rdata_o   = rdata_q;
    assign rresp_o   = rresp_q;
    assign awready_o = awready_q;
    assign wready_o  = wready_q;
    assign bvalid_o  = bvalid_q;
    assign bresp_o   = bresp_q;
    assign msip_o    = msip_q;
    assign mtip_o    = mtip_q;

endmodule

// File: tb/tb_clint_multi.sv
// Directed bench: dut0 has two harts at TICK_DIV=1, dut1 one hart at TICK_DIV=4.
module tb_clint_multi;
    import clint_pkg::*;

    localparam logic [31:0] BASE = 32'h0200_0000;

    logic clock = 1'b0;
    logic reset;
    logic [1:0]  arvalid, arready, rvalid, rready, awvalid, awready, wvalid, wready, bvalid, bready;
    logic [31:0] araddr [2];
    logic [31:0] rdata  [2];
    logic [31:0] awaddr [2];
    logic [31:0] wdata  [2];
    logic [1:0]  rresp  [2];
    logic [1:0]  bresp  [2];
    logic [3:0]  wstrb  [2];
    logic [1:0]  msip0, mtip0;
    logic [0:0]  msip1, mtip1;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    clint_multi #(.BASE_ADDR(BASE), .NUM_HARTS(2), .TICK_DIV(1)) u_dut0 (
        .clock(clock), .reset(reset),
        .arvalid_i(arvalid[0]), .arready_o(arready[0]), .araddr_i(araddr[0]),
        .rvalid_o(rvalid[0]), .rready_i(rready[0]), .rdata_o(rdata[0]), .rresp_o(rresp[0]),
        .awvalid_i(awvalid[0]), .awready_o(awready[0]), .awaddr_i(awaddr[0]),
        .wvalid_i(wvalid[0]), .wready_o(wready[0]), .wdata_i(wdata[0]), .wstrb_i(wstrb[0]),
        .bvalid_o(bvalid[0]), .bready_i(bready[0]), .bresp_o(bresp[0]),
        .msip_o(msip0), .mtip_o(mtip0)
    );

    clint_multi #(.BASE_ADDR(BASE), .NUM_HARTS(1), .TICK_DIV(4)) u_dut1 (
        .clock(clock), .reset(reset),
        .arvalid_i(arvalid[1]), .arready_o(arready[1]), .araddr_i(araddr[1]),
        .rvalid_o(rvalid[1]), .rready_i(rready[1]), .rdata_o(rdata[1]), .rresp_o(rresp[1]),
        .awvalid_i(awvalid[1]), .awready_o(awready[1]), .awaddr_i(awaddr[1]),
        .wvalid_i(wvalid[1]), .wready_o(wready[1]), .wdata_i(wdata[1]), .wstrb_i(wstrb[1]),
        .bvalid_o(bvalid[1]), .bready_i(bready[1]), .bresp_o(bresp[1]),
        .msip_o(msip1), .mtip_o(mtip1)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // AR handshake at the next edge, R handshake one edge later.
    task automatic rd(input int d, input logic [15:0] off,
                      output logic [31:0] data, output logic [1:0] resp);
        int   n;
        logic hs;
        araddr[d]  = BASE + 32'(off);
        arvalid[d] = 1'b1;
        n  = 0;
        hs = 1'b0;
        while (!hs && n < 20) begin
            hs = arready[d];
            tick();
            n++;
        end
        arvalid[d] = 1'b0;
        check("ar_handshake", 64'(hs), 64'd1);
        check("r_latency", 64'(rvalid[d]), 64'd1);
        n = 0;
        while (!rvalid[d] && n < 20) begin
            tick();
            n++;
        end
        data      = rdata[d];
        resp      = rresp[d];
        rready[d] = 1'b1;
        tick();
        rready[d] = 1'b0;
    endtask

    // AW and W offered together; B taken immediately.
    task automatic wr(input int d, input logic [15:0] off, input logic [31:0] data,
                      input logic [3:0] strb, output logic [1:0] resp);
        int   n;
        logic a_done, w_done, a_hs, w_hs;
        awaddr[d]  = BASE + 32'(off);
        wdata[d]   = data;
        wstrb[d]   = strb;
        awvalid[d] = 1'b1;
        wvalid[d]  = 1'b1;
        a_done = 1'b0;
        w_done = 1'b0;
        n = 0;
        while (!(a_done && w_done) && n < 20) begin
            a_hs = awvalid[d] && awready[d];
            w_hs = wvalid[d] && wready[d];
            tick();
            if (a_hs) begin a_done = 1'b1; awvalid[d] = 1'b0; end
            if (w_hs) begin w_done = 1'b1; wvalid[d] = 1'b0; end
            n++;
        end
        awvalid[d] = 1'b0;
        wvalid[d]  = 1'b0;
        check("aw_w_handshake", 64'(a_done && w_done), 64'd1);
        check("b_latency", 64'(bvalid[d]), 64'd1);
        n = 0;
        while (!bvalid[d] && n < 20) begin
            tick();
            n++;
        end
        resp      = bresp[d];
        bready[d] = 1'b1;
        tick();
        bready[d] = 1'b0;
    endtask

    initial begin
        logic [31:0] d32;
        logic [1:0]  r2;

        reset = 1'b0;
        arvalid = '0; rready = '0; awvalid = '0; wvalid = '0; bready = '0;
        for (int i = 0; i < 2; i++) begin
            araddr[i] = '0; awaddr[i] = '0; wdata[i] = '0; wstrb[i] = '0;
        end

        // Reset state
        tick(2);
        check("rst_ready_valid0", {arready[0], awready[0], wready[0], rvalid[0], bvalid[0]}, 64'b11100);
        check("rst_ready_valid1", {arready[1], awready[1], wready[1], rvalid[1], bvalid[1]}, 64'b11100);
        check("rst_irq0", {msip0, mtip0}, 64'd0);
        check("rst_irq1", {msip1, mtip1}, 64'd0);
        check("rst_rdata_resp", {rdata[0], rresp[0], bresp[0]}, 64'd0);

        // mtime counts every cycle after release; legacy alias mirrors it
        reset = 1'b1;
        tick(10);
        rd(0, MTIME_OFF, d32, r2);
        check("mtime_lo_after_10", d32, 64'd10);
        check("mtime_lo_resp", r2, 64'(RESP_OKAY));
        rd(0, LEGACY_MTIME_OFF, d32, r2);
        check("legacy_lo", d32, 64'd12);
        check("legacy_lo_resp", r2, 64'(RESP_OKAY));
        rd(0, LEGACY_MTIME_OFF + 16'd4, d32, r2);
        check("legacy_hi", d32, 64'd0);

        // W before AW, 3-cycle gap, then held B
        wdata[0] = 32'd1;
        wstrb[0] = 4'b0001;
        wvalid[0] = 1'b1;
        check("w_ready_idle", 64'(wready[0]), 64'd1);
        tick();
        wvalid[0] = 1'b0;
        check("have_d_ready", {awready[0], wready[0]}, 64'b10);
        tick(3);
        check("msip_before_aw", msip0, 64'd0);
        awaddr[0] = BASE + 32'(MSIP_OFF);
        awvalid[0] = 1'b1;
        tick();
        awvalid[0] = 1'b0;
        check("msip0_set", msip0, 64'b01);
        check("bresp_msip", bresp[0], 64'(RESP_OKAY));
        check("resp_ready", {awready[0], wready[0]}, 64'b00);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bvalid_held", 64'(bvalid[0]), 64'd1);
        end
        bready[0] = 1'b1;
        tick();
        bready[0] = 1'b0;
        check("b_done", {bvalid[0], awready[0], wready[0]}, 64'b011);
        rd(0, MSIP_OFF, d32, r2);
        check("msip0_readback", d32, 64'd1);
        wr(0, MSIP_OFF + 16'd4, 32'd1, 4'b0000, r2);
        check("msip1_nostrb", msip0, 64'b01);

        // mtimecmp[1] = 100, then mtime = 80: mtip[1] rises exactly 21 edges later
        wr(0, MTIMECMP_OFF + 16'd8, 32'd100, 4'hF, r2);
        wr(0, MTIMECMP_OFF + 16'd12, 32'd0, 4'hF, r2);
        wr(0, MTIME_OFF, 32'd80, 4'hF, r2);
        check("mtip_after_mtime_wr", mtip0, 64'b00);
        tick(19);
        check("mtip_before_rise", mtip0, 64'b00);
        tick();
        check("mtip_rise", mtip0, 64'b10);
        wr(0, MTIMECMP_OFF + 16'd12, 32'hFFFF_FFFF, 4'hF, r2);
        check("mtip_fall", mtip0, 64'b00);
        wr(0, MTIMECMP_OFF + 16'd8, 32'hFFFF_FFFF, 4'hF, r2);
        rd(0, MTIMECMP_OFF + 16'd8, d32, r2);
        check("cmp1_lo", d32, 64'hFFFF_FFFF);
        rd(0, MTIMECMP_OFF + 16'd4, d32, r2);
        check("cmp0_hi_reset", d32, 64'hFFFF_FFFF);

        // Byte strobes on mtimecmp[0] low word
        wr(0, MTIMECMP_OFF, 32'h1122_3344, 4'b0101, r2);
        rd(0, MTIMECMP_OFF, d32, r2);
        check("cmp0_lo_strb", d32, 64'hFF22_FF44);

        // Error responses
        wr(0, LEGACY_MTIME_OFF, 32'd5, 4'hF, r2);
        check("legacy_wr_resp", r2, 64'(RESP_SLVERR));
        rd(0, 16'h1234, d32, r2);
        check("unmapped_rd", {d32, r2}, 64'(RESP_SLVERR));
        rd(0, 16'hBFF9, d32, r2);
        check("unaligned_rd", {d32, r2}, 64'(RESP_SLVERR));
        rd(0, MSIP_OFF + 16'd8, d32, r2);
        check("msip_hart2_rd", {d32, r2}, 64'(RESP_SLVERR));

        // Read backpressure with AR held: data frozen, no second AR
        wr(0, MTIME_OFF, 32'd1000, 4'hF, r2);
        araddr[0] = BASE + 32'(MTIME_OFF);
        arvalid[0] = 1'b1;
        tick();
        check("bp_first", {rvalid[0], rdata[0]}, {32'd1, 32'd1001});
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_hold", {arready[0], rvalid[0], rdata[0]}, {31'd0, 1'b1, 32'd1001});
        end
        rready[0] = 1'b1;
        tick();
        rready[0] = 1'b0;
        arvalid[0] = 1'b0;
        check("bp_release", {rvalid[0], arready[0]}, 64'b01);
        rd(0, MTIME_OFF, d32, r2);
        check("bp_mtime_advanced", d32, 64'd1006);

        // TICK_DIV=4: low-word wrap carries into high only via the prescaled tick
        wr(1, MTIME_OFF, 32'hFFFF_FFFF, 4'hF, r2);
        wr(1, MTIME_OFF + 16'd4, 32'd0, 4'hF, r2);
        tick(3);
        rd(1, MTIME_OFF + 16'd4, d32, r2);
        check("div4_hi", d32, 64'd1);
        rd(1, MTIME_OFF, d32, r2);
        check("div4_lo", d32, 64'd0);
        rd(1, MTIME_OFF, d32, r2);
        check("div4_lo_next", d32, 64'd1);
        check("dut1_irq", {msip1, mtip1}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
